// File: rtl/pk_hasti.sv
// Shared HASTI (AHB-Lite) bus definitions.
// Transfer, response and size encodings plus SRAM slave helpers.
package pk_hasti;

  typedef logic [1:0] t_htrans;
  localparam t_htrans HTRANS_IDLE   = 2'b00;
  localparam t_htrans HTRANS_BUSY   = 2'b01;
  localparam t_htrans HTRANS_NONSEQ = 2'b10;
  localparam t_htrans HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef logic [2:0] t_hsize;
  localparam t_hsize HSIZE_BYTE = 3'd0;
  localparam t_hsize HSIZE_HALF = 3'd1;
  localparam t_hsize HSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } t_sram_state;

  function automatic logic [3:0] byte_strobe(
    input t_hsize     sz,
    input logic [1:0] a
  );
    logic [3:0] be;
    be = 4'b0000;
    case (sz)
      HSIZE_BYTE: be = 4'b0001 << a;
      HSIZE_HALF: be = 4'b0011 << {a[1], 1'b0};
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic xfer_legal(
    input t_hsize     sz,
    input logic [1:0] a
  );
    return (sz == HSIZE_BYTE)
        || (sz == HSIZE_HALF && !a[0])
        || (sz == HSIZE_WORD && a == 2'b00);
  endfunction

  function automatic logic [31:0] be_mask(
    input logic [3:0] be
  );
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/sram_1r1w_be.sv
// Single-clock SRAM, one synchronous read port and one byte-enable write port.
// Read-during-write to the same word returns the old contents.
module sram_1r1w_be #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_o <= mem[raddr_i];
    end
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/hasti_sram_slave.sv
// AHB-Lite slave fronting an on-chip SRAM: byte/half/word access,
// programmable wait states and two-cycle ERROR for illegal transfers.
module hasti_sram_slave
  import pk_hasti::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [3:0]  hprot,
  input  logic [1:0]  htrans,
  input  logic        hmastlock,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp
);

  localparam int AW = $clog2(DEPTH_WORDS);

  t_sram_state state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;

  logic          acc;
  logic          legal;
  logic          commit;
  logic          rd_acc;
  logic [AW-1:0] idx;

  logic          wr_pend_q;
  logic [AW-1:0] wr_idx_q;
  logic [3:0]    wr_be_q;
  logic          rd_vld_q;
  logic          fwd_q;
  logic [31:0]   fwd_data_q;
  logic [31:0]   fwd_mask_q;
  logic [31:0]   ram_rdata;

  logic unused_ok;
  assign unused_ok = ^{hburst, hprot, hmastlock,
                       htrans[0], haddr[31:AW+2]};

  assign acc    = hsel & hready & htrans[1];
  assign legal  = xfer_legal(hsize, haddr[1:0]);
  assign idx    = haddr[AW+1:2];
  assign rd_acc = acc & legal & ~hwrite;
  // Data phase of a pending write ends on this edge.
  assign commit = wr_pend_q & hreadyout & hready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    unique case (state_q)
      ST_IDLE, ST_ERR2: begin
        if (state_q == ST_ERR2) begin
          hresp = HRESP_ERROR;
        end
        state_d = ST_IDLE;
        if (acc) begin
          if (!legal) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES != 0) begin
            state_d = ST_WAIT;
            cnt_d   = 2'(WAIT_STATES);
          end
        end
      end
      ST_WAIT: begin
        hreadyout = 1'b0;
        cnt_d     = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          state_d = ST_IDLE;
        end
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
        state_d   = ST_ERR2;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 2'd0;
      wr_pend_q <= 1'b0;
      rd_vld_q  <= 1'b0;
      fwd_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (acc) begin
        wr_pend_q <= legal & hwrite;
        rd_vld_q  <= rd_acc;
        fwd_q     <= rd_acc & commit & (idx == wr_idx_q);
      end else if (commit) begin
        wr_pend_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (acc) begin
      wr_idx_q <= idx;
      wr_be_q  <= byte_strobe(hsize, haddr[1:0]);
    end
    // Capture the committing write so a same-word read can merge it.
    if (acc & commit) begin
      fwd_data_q <= hwdata;
      fwd_mask_q <= be_mask(wr_be_q);
    end
  end

  sram_1r1w_be #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk_i  (hclk),
    .re_i   (rd_acc),
    .raddr_i(idx),
    .rdata_o(ram_rdata),
    .we_i   (commit & ~hreset),
    .waddr_i(wr_idx_q),
    .be_i   (wr_be_q),
    .wdata_i(hwdata)
  );

  always_comb begin
    hrdata = 32'd0;
    if (rd_vld_q) begin
      hrdata = fwd_q
             ? ((ram_rdata & ~fwd_mask_q) | (fwd_data_q & fwd_mask_q))
             : ram_rdata;
    end
  end

endmodule

// File: tb/tb_hasti_sram_slave.sv
// Directed bench for hasti_sram_slave: one instance with zero wait
// states and one with two, sharing the address/data bus.
module tb_hasti_sram_slave;
  import pk_hasti::*;

  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  logic        sel0, sel2;
  logic [31:0] haddr, hwdata;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst = 3'd0;
  logic [3:0]  hprot = 4'd0;
  logic [1:0]  htrans;
  logic        hmastlock = 1'b0;
  logic [31:0] rd0, rd2;
  logic        ro0, ro2, rs0, rs2;

  int errs = 0;
  int checks = 0;

  always #5 hclk = ~hclk;

  hasti_sram_slave #(.DEPTH_WORDS(64), .WAIT_STATES(0)) u_dut0 (
    .hclk(hclk), .hreset(hreset), .hsel(sel0), .haddr(haddr),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
    .htrans(htrans), .hmastlock(hmastlock), .hwdata(hwdata),
    .hready(ro0), .hrdata(rd0), .hreadyout(ro0), .hresp(rs0)
  );

  hasti_sram_slave #(.DEPTH_WORDS(64), .WAIT_STATES(2)) u_dut2 (
    .hclk(hclk), .hreset(hreset), .hsel(sel2), .haddr(haddr),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
    .htrans(htrans), .hmastlock(hmastlock), .hwdata(hwdata),
    .hready(ro2), .hrdata(rd2), .hreadyout(ro2), .hresp(rs2)
  );

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic ap(input logic s0, input logic s2,
                    input logic [31:0] a, input logic w,
                    input logic [2:0] sz);
    sel0   = s0;
    sel2   = s2;
    haddr  = a;
    hwrite = w;
    hsize  = sz;
    htrans = HTRANS_NONSEQ;
  endtask

  task automatic idle();
    sel0   = 1'b0;
    sel2   = 1'b0;
    htrans = HTRANS_IDLE;
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    idle();
    step();
    step();
    checks++; if (ro0 !== 1'b1) begin errs++; $display("FAIL rst_ro0 got=%b exp=1", ro0); end
    checks++; if (rs0 !== 1'b0) begin errs++; $display("FAIL rst_rs0 got=%b exp=0", rs0); end
    checks++; if (rd0 !== 32'd0) begin errs++; $display("FAIL rst_rd0 got=%h exp=0", rd0); end
    checks++; if (ro2 !== 1'b1) begin errs++; $display("FAIL rst_ro2 got=%b exp=1", ro2); end
    checks++; if (rs2 !== 1'b0) begin errs++; $display("FAIL rst_rs2 got=%b exp=0", rs2); end
    checks++; if (rd2 !== 32'd0) begin errs++; $display("FAIL rst_rd2 got=%h exp=0", rd2); end
    hreset = 1'b0;
    step();
  endtask

  task automatic test_forward_word();
    ap(1, 0, 32'h10, 1, HSIZE_WORD);
    step();
    hwdata = 32'hDEADBEEF;
    ap(1, 0, 32'h10, 0, HSIZE_WORD);
    step();
    idle();
    checks++; if (rd0 !== 32'hDEADBEEF) begin errs++; $display("FAIL fwd_rd got=%h exp=deadbeef", rd0); end
    checks++; if (ro0 !== 1'b1) begin errs++; $display("FAIL fwd_ro got=%b exp=1", ro0); end
    checks++; if (rs0 !== 1'b0) begin errs++; $display("FAIL fwd_rs got=%b exp=0", rs0); end
    step();
    ap(1, 0, 32'h10, 0, HSIZE_WORD);
    step();
    idle();
    checks++; if (rd0 !== 32'hDEADBEEF) begin errs++; $display("FAIL arr_rd got=%h exp=deadbeef", rd0); end
    step();
  endtask

  task automatic test_byte_merge();
    ap(1, 0, 32'h20, 1, HSIZE_WORD);
    step();
    hwdata = 32'h11223344;
    ap(1, 0, 32'h22, 1, HSIZE_BYTE);
    step();
    hwdata = 32'hFFAAFFFF;
    ap(1, 0, 32'h20, 0, HSIZE_HALF);
    step();
    idle();
    checks++; if (rd0 !== 32'h11AA3344) begin errs++; $display("FAIL byte_fwd got=%h exp=11aa3344", rd0); end
    checks++; if (ro0 !== 1'b1) begin errs++; $display("FAIL byte_ro got=%b exp=1", ro0); end
    step();
  endtask

  task automatic test_error();
    ap(1, 0, 32'h21, 1, HSIZE_WORD);
    step();
    hwdata = 32'h00000000;
    idle();
    checks++; if (ro0 !== 1'b0 || rs0 !== 1'b1) begin errs++; $display("FAIL mis_err1 got=%b%b exp=01", ro0, rs0); end
    step();
    checks++; if (ro0 !== 1'b1 || rs0 !== 1'b1) begin errs++; $display("FAIL mis_err2 got=%b%b exp=11", ro0, rs0); end
    step();
    checks++; if (ro0 !== 1'b1 || rs0 !== 1'b0) begin errs++; $display("FAIL mis_done got=%b%b exp=10", ro0, rs0); end
    ap(1, 0, 32'h20, 0, HSIZE_WORD);
    step();
    idle();
    checks++; if (rd0 !== 32'h11AA3344) begin errs++; $display("FAIL mis_nowr got=%h exp=11aa3344", rd0); end
    ap(1, 0, 32'h20, 0, 3'd3);
    step();
    ap(1, 0, 32'h10, 0, HSIZE_WORD);
    checks++; if (ro0 !== 1'b0 || rs0 !== 1'b1) begin errs++; $display("FAIL sz_err1 got=%b%b exp=01", ro0, rs0); end
    step();
    checks++; if (ro0 !== 1'b1 || rs0 !== 1'b1) begin errs++; $display("FAIL sz_err2 got=%b%b exp=11", ro0, rs0); end
    step();
    idle();
    checks++; if (ro0 !== 1'b1 || rs0 !== 1'b0) begin errs++; $display("FAIL err2_acc got=%b%b exp=10", ro0, rs0); end
    checks++; if (rd0 !== 32'hDEADBEEF) begin errs++; $display("FAIL err2_rd got=%h exp=deadbeef", rd0); end
    step();
  endtask

  task automatic test_unselected();
    ap(0, 0, 32'h10, 1, HSIZE_WORD);
    step();
    hwdata = 32'h0BADF00D;
    idle();
    checks++; if (ro0 !== 1'b1 || rs0 !== 1'b0) begin errs++; $display("FAIL unsel_resp got=%b%b exp=10", ro0, rs0); end
    step();
    ap(1, 0, 32'h10, 0, HSIZE_WORD);
    step();
    idle();
    checks++; if (rd0 !== 32'hDEADBEEF) begin errs++; $display("FAIL unsel_nowr got=%h exp=deadbeef", rd0); end
    step();
  endtask

  task automatic test_back_to_back();
    ap(1, 0, 32'h30, 1, HSIZE_WORD);
    step();
    hwdata = 32'hA1A1A1A1;
    ap(1, 0, 32'h34, 1, HSIZE_WORD);
    step();
    hwdata = 32'hB2B2B2B2;
    ap(1, 0, 32'h30, 0, HSIZE_WORD);
    step();
    ap(1, 0, 32'h34, 0, HSIZE_WORD);
    checks++; if (rd0 !== 32'hA1A1A1A1) begin errs++; $display("FAIL b2b_rd0 got=%h exp=a1a1a1a1", rd0); end
    step();
    idle();
    checks++; if (rd0 !== 32'hB2B2B2B2) begin errs++; $display("FAIL b2b_rd1 got=%h exp=b2b2b2b2", rd0); end
    step();
  endtask

  task automatic test_wrap();
    ap(1, 0, 32'h104, 1, HSIZE_WORD);
    step();
    hwdata = 32'hCAFEF00D;
    idle();
    step();
    ap(1, 0, 32'h04, 0, HSIZE_WORD);
    step();
    idle();
    checks++; if (rd0 !== 32'hCAFEF00D) begin errs++; $display("FAIL wrap_rd got=%h exp=cafef00d", rd0); end
    step();
  endtask

  task automatic test_wait_states();
    ap(0, 1, 32'h40, 1, HSIZE_WORD);
    step();
    hwdata = 32'h5A5A1234;
    ap(0, 1, 32'h40, 0, HSIZE_WORD);
    checks++; if (ro2 !== 1'b0 || rs2 !== 1'b0) begin errs++; $display("FAIL ws_w0 got=%b%b exp=00", ro2, rs2); end
    step();
    checks++; if (ro2 !== 1'b0) begin errs++; $display("FAIL ws_w1 got=%b exp=0", ro2); end
    step();
    checks++; if (ro2 !== 1'b1) begin errs++; $display("FAIL ws_w2 got=%b exp=1", ro2); end
    step();
    idle();
    checks++; if (ro2 !== 1'b0 || rd2 !== 32'h5A5A1234) begin errs++; $display("FAIL ws_r0 got=%b %h exp=0 5a5a1234", ro2, rd2); end
    step();
    checks++; if (ro2 !== 1'b0 || rd2 !== 32'h5A5A1234) begin errs++; $display("FAIL ws_r1 got=%b %h exp=0 5a5a1234", ro2, rd2); end
    step();
    checks++; if (ro2 !== 1'b1 || rd2 !== 32'h5A5A1234) begin errs++; $display("FAIL ws_r2 got=%b %h exp=1 5a5a1234", ro2, rd2); end
    step();
  endtask

  task automatic test_reset_mid_write();
    ap(0, 1, 32'h40, 1, HSIZE_WORD);
    step();
    hwdata = 32'hFFFFFFFF;
    idle();
    hreset = 1'b1;
    step();
    hreset = 1'b0;
    checks++; if (ro2 !== 1'b1 || rs2 !== 1'b0) begin errs++; $display("FAIL mid_rst got=%b%b exp=10", ro2, rs2); end
    checks++; if (rd2 !== 32'd0) begin errs++; $display("FAIL mid_rst_rd got=%h exp=0", rd2); end
    step();
    step();
    step();
    ap(0, 1, 32'h40, 0, HSIZE_WORD);
    step();
    idle();
    step();
    step();
    checks++; if (ro2 !== 1'b1 || rd2 !== 32'h5A5A1234) begin errs++; $display("FAIL mid_nowr got=%b %h exp=1 5a5a1234", ro2, rd2); end
    step();
  endtask

  initial begin
    sel0   = 1'b0;
    sel2   = 1'b0;
    haddr  = 32'd0;
    hwrite = 1'b0;
    hsize  = HSIZE_WORD;
    htrans = HTRANS_IDLE;
    hwdata = 32'd0;
    test_reset();
    test_forward_word();
    test_byte_merge();
    test_error();
    test_unselected();
    test_back_to_back();
    test_wrap();
    test_wait_states();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
